// File: rtl/doa_sequencer.sv
// Frame scheduler for the DOA chain: capture -> FFT -> detect -> beam search.
// Optional `DOA_AVG_EN: doa_out is the running average of the last 4 results.
module doa_sequencer #(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int HOLDOFF_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              single,
  input  logic              clr_err,
  input  logic              frame_ready,
  output logic              frame_ack,
  output logic              fft_start,
  input  logic [3:0]        fft_done,
  output logic              detect_start,
  input  logic              detectdone,
  input  logic              wb_done,
  input  logic signed [7:0] doa_in,
  input  logic [5:0]        bnum_in,
  output logic signed [7:0] doa_out,
  output logic [5:0]        bnum_out,
  output logic              doa_valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_stage,
  output logic [15:0]       frame_cnt
);

  localparam int TMAX =
    (TIMEOUT_CYC > HOLDOFF_CYC) ? TIMEOUT_CYC : HOLDOFF_CYC;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_FFT  = 3'd2;
  localparam logic [2:0] S_DET  = 3'd3;
  localparam logic [2:0] S_BEAM = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]  state;
  logic        single_mode;
  logic [3:0]  fft_seen;
  logic [3:0]  fft_all;
  logic [TW-1:0] timer;
  logic        dd_q;
  logic        t_exp;
  logic        hold_end;
  logic        accept;
  logic [7:0]  doa_next;

  assign fft_all  = fft_seen | fft_done;
  assign t_exp    = (timer == TW'(TIMEOUT_CYC - 1));
  assign hold_end = (timer == TW'(HOLDOFF_CYC - 1));
  assign accept   = (state == S_BEAM) && wb_done;
  assign busy     = !((state == S_IDLE) || (state == S_ERR));
  assign err      = (state == S_ERR);

`ifdef DOA_AVG_EN
  logic [7:0] h0, h1, h2;
  logic [1:0] hcnt;
  logic [9:0] sum;

  always_comb begin
    sum = {{2{doa_in[7]}}, doa_in}
        + {{2{h0[7]}}, h0}
        + {{2{h1[7]}}, h1}
        + {{2{h2[7]}}, h2};
    // sum[9:2] is an arithmetic shift, rounding toward -inf
    doa_next = (hcnt == 2'd3) ? sum[9:2] : doa_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h0   <= '0;
      h1   <= '0;
      h2   <= '0;
      hcnt <= '0;
    end else if (accept) begin
      h0 <= doa_in;
      h1 <= h0;
      h2 <= h1;
      if (hcnt != 2'd3) hcnt <= hcnt + 2'd1;
    end
  end
`else
  assign doa_next = doa_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      single_mode  <= 1'b0;
      fft_seen     <= '0;
      timer        <= '0;
      dd_q         <= 1'b0;
      frame_ack    <= 1'b0;
      fft_start    <= 1'b0;
      detect_start <= 1'b0;
      doa_valid    <= 1'b0;
      doa_out      <= '0;
      bnum_out     <= '0;
      err_stage    <= '0;
      frame_cnt    <= '0;
    end else begin
      frame_ack    <= 1'b0;
      fft_start    <= 1'b0;
      detect_start <= 1'b0;
      doa_valid    <= 1'b0;
      dd_q         <= detectdone;
      case (state)
        S_IDLE: begin
          if (run || single) begin
            state       <= S_WAIT;
            single_mode <= !run;
          end
        end
        S_WAIT: begin
          if (frame_ready) begin
            frame_ack <= 1'b1;
            fft_start <= 1'b1;
            fft_seen  <= '0;
            timer     <= '0;
            state     <= S_FFT;
          end else if (!run && !single_mode) begin
            state <= S_IDLE;
          end
        end
        S_FFT: begin
          fft_seen <= fft_all;
          if (&fft_all) begin
            detect_start <= 1'b1;
            timer        <= '0;
            state        <= S_DET;
          end else if (t_exp) begin
            err_stage <= 2'd1;
            state     <= S_ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DET: begin
          if (detectdone && !dd_q) begin
            timer <= '0;
            state <= S_BEAM;
          end else if (t_exp) begin
            err_stage <= 2'd2;
            state     <= S_ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_BEAM: begin
          if (wb_done) begin
            doa_out   <= doa_next;
            bnum_out  <= bnum_in;
            doa_valid <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            timer     <= '0;
            state     <= S_HOLD;
          end else if (t_exp) begin
            err_stage <= 2'd3;
            state     <= S_ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_HOLD: begin
          if (hold_end) begin
            state <= (run && !single_mode) ? S_WAIT : S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_ERR: begin
          if (clr_err) begin
            err_stage <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doa_sequencer.sv
// Directed bench for doa_sequencer (TIMEOUT_CYC=100, HOLDOFF_CYC=10).
// Expected results follow `DOA_AVG_EN when it is defined.
module tb_doa_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        single = 1'b0;
  logic        clr_err = 1'b0;
  logic        frame_ready = 1'b0;
  logic        frame_ack;
  logic        fft_start;
  logic [3:0]  fft_done = '0;
  logic        detect_start;
  logic        detectdone = 1'b0;
  logic        wb_done = 1'b0;
  logic [7:0]  doa_in = '0;
  logic [5:0]  bnum_in = '0;
  logic [7:0]  doa_out;
  logic [5:0]  bnum_out;
  logic        doa_valid;
  logic        busy;
  logic        err;
  logic [1:0]  err_stage;
  logic [15:0] frame_cnt;

  int ntests = 0;
  int nfail = 0;
  int n_ack = 0;
  int n_fs = 0;
  int n_ds = 0;
  int n_dv = 0;

  always #5 clk = ~clk;

  doa_sequencer #(.TIMEOUT_CYC(100), .HOLDOFF_CYC(10)) dut (
    .clk(clk), .reset(reset), .run(run), .single(single),
    .clr_err(clr_err), .frame_ready(frame_ready),
    .frame_ack(frame_ack), .fft_start(fft_start),
    .fft_done(fft_done), .detect_start(detect_start),
    .detectdone(detectdone), .wb_done(wb_done),
    .doa_in(doa_in), .bnum_in(bnum_in),
    .doa_out(doa_out), .bnum_out(bnum_out),
    .doa_valid(doa_valid), .busy(busy), .err(err),
    .err_stage(err_stage), .frame_cnt(frame_cnt)
  );

  always @(posedge clk) begin
    if (frame_ack) n_ack++;
    if (fft_start) n_fs++;
    if (detect_start) n_ds++;
    if (doa_valid) n_dv++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fft(output int n);
    n = 0;
    while (fft_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("fft_start_seen", 32'(fft_start), 32'd1);
  endtask

  task automatic pulse_single();
    single = 1'b1;
    tick();
    single = 1'b0;
  endtask

  task automatic frame_body(input logic [7:0] d,
                            input logic [5:0] b,
                            input logic [7:0] expd,
                            input bit pre_high);
    fft_done = 4'b1000;
    tick();
    fft_done = 4'b0001;
    tick();
    fft_done = 4'b0100;
    tick();
    fft_done = 4'b0010;
    if (pre_high) detectdone = 1'b1;
    tick();
    fft_done = 4'b0000;
    chk("detect_start", 32'(detect_start), 32'd1);
    doa_in  = d;
    bnum_in = b;
    if (pre_high) begin
      wb_done = 1'b1;
      tick();
      wb_done = 1'b0;
      chk("no_edge_no_beam", 32'(doa_valid), 32'd0);
      detectdone = 1'b0;
      tick();
    end
    detectdone = 1'b1;
    tick();
    detectdone = 1'b0;
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    chk("doa_valid", 32'(doa_valid), 32'd1);
    chk("doa_out", 32'(doa_out), 32'(expd));
    chk("bnum_out", 32'(bnum_out), 32'(b));
    tick();
    chk("doa_valid_1cyc", 32'(doa_valid), 32'd0);
  endtask

  logic [7:0] din [5];
  logic [7:0] dexp [5];
  logic [7:0] e3;
  logic [7:0] e4;

  initial begin
    int n;
    int s_ack, s_fs, s_ds, s_dv;

    din[0] = 8'd10;
    din[1] = 8'd20;
    din[2] = -8'sd30;
    din[3] = 8'd40;
    din[4] = 8'd50;
`ifdef DOA_AVG_EN
    dexp[0] = 8'd10;
    dexp[1] = 8'd20;
    dexp[2] = -8'sd30;
    dexp[3] = 8'd10;
    dexp[4] = 8'd20;
    e3 = -8'sd4;
    e4 = 8'd15;
`else
    for (int i = 0; i < 5; i++) dexp[i] = din[i];
    e3 = 8'd9;
    e4 = 8'd40;
`endif

    // reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_doa_out", 32'(doa_out), 32'd0);
    chk("rst_fft_start", 32'(fft_start), 32'd0);
    reset = 1'b1;
    tick();

    // single frame, done bits in order 3,0,2,1
    frame_ready = 1'b1;
    s_ack = n_ack; s_fs = n_fs; s_ds = n_ds; s_dv = n_dv;
    pulse_single();
    wait_fft(n);
    chk("t1_busy", 32'(busy), 32'd1);
    frame_body(-8'sd35, 6'd11, -8'sd35, 1'b0);
    repeat (12) tick();
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_ack_cnt", 32'(n_ack - s_ack), 32'd1);
    chk("t1_fs_cnt", 32'(n_fs - s_fs), 32'd1);
    chk("t1_ds_cnt", 32'(n_ds - s_ds), 32'd1);
    chk("t1_dv_cnt", 32'(n_dv - s_dv), 32'd1);

    // continuous mode, three frames, run dropped in the third
    s_dv = n_dv;
    run = 1'b1;
    wait_fft(n);
    frame_body(8'd5, 6'd1, 8'd5, 1'b0);
    wait_fft(n);
    chk("t2_gap1", 32'(n >= 10), 32'd1);
    frame_body(8'd7, 6'd2, 8'd7, 1'b0);
    wait_fft(n);
    chk("t2_gap2", 32'(n >= 10), 32'd1);
    run = 1'b0;
    frame_body(8'd9, 6'd3, e3, 1'b0);
    repeat (12) tick();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd4);
    s_fs = n_fs;
    repeat (20) tick();
    chk("t2_no_restart", 32'(n_fs - s_fs), 32'd0);
    chk("t2_dv_cnt", 32'(n_dv - s_dv), 32'd3);

    // FFT timeout with one channel missing
    s_ds = n_ds;
    pulse_single();
    wait_fft(n);
    fft_done = 4'b0111;
    tick();
    fft_done = 4'b0000;
    repeat (98) tick();
    chk("t3_no_err_yet", 32'(err), 32'd0);
    tick();
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_err_stage", 32'(err_stage), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    fft_done = 4'b1000;
    tick();
    fft_done = 4'b0000;
    tick();
    chk("t3_err_hold", 32'(err), 32'd1);
    chk("t3_late_done", 32'(n_ds - s_ds), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_clr_err", 32'(err), 32'd0);
    chk("t3_clr_stage", 32'(err_stage), 32'd0);
    chk("t3_clr_busy", 32'(busy), 32'd0);
    chk("t3_doa_kept", 32'(doa_out), 32'(e3));

    // wb_done on the BEAM expiry cycle
    pulse_single();
    wait_fft(n);
    fft_done = 4'hF;
    tick();
    fft_done = 4'h0;
    chk("t4_detect_start", 32'(detect_start), 32'd1);
    detectdone = 1'b1;
    tick();
    detectdone = 1'b0;
    repeat (99) tick();
    chk("t4_pre_err", 32'(err), 32'd0);
    doa_in  = 8'd40;
    bnum_in = 6'd36;
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    chk("t4_valid", 32'(doa_valid), 32'd1);
    chk("t4_doa", 32'(doa_out), 32'(e4));
    chk("t4_bnum", 32'(bnum_out), 32'd36);
    chk("t4_err", 32'(err), 32'd0);
    tick();
    chk("t4_err_after", 32'(err), 32'd0);
    repeat (12) tick();
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd5);

    // asynchronous reset during DETECT
    pulse_single();
    wait_fft(n);
    fft_done = 4'hF;
    tick();
    fft_done = 4'h0;
    chk("t5_detect_start", 32'(detect_start), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_doa_out", 32'(doa_out), 32'd0);
    chk("t5_bnum_out", 32'(bnum_out), 32'd0);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_err_stage", 32'(err_stage), 32'd0);
    s_fs = n_fs; s_ds = n_ds; s_dv = n_dv;
    detectdone = 1'b1;
    wb_done = 1'b1;
    tick();
    wb_done = 1'b0;
    tick();
    reset = 1'b1;
    repeat (20) tick();
    detectdone = 1'b0;
    chk("t5_no_fs", 32'(n_fs - s_fs), 32'd0);
    chk("t5_no_ds", 32'(n_ds - s_ds), 32'd0);
    chk("t5_no_dv", 32'(n_dv - s_dv), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // result sequence (averaged when enabled); first frame checks edge rule
    for (int i = 0; i < 5; i++) begin
      pulse_single();
      wait_fft(n);
      frame_body(din[i], 6'(i + 20), dexp[i], i == 0);
      repeat (12) tick();
    end
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/doa_sequencer.md
Name: doa_sequencer

Overview:
- Top-level frame scheduler for the DOA chain: capture buffer -> 4-channel FFT -> frequency detect -> beam weight search.
- Issues start pulses to each stage and collects their done pulses.
- Enforces one frame in flight, runs a per-stage watchdog, and latches the final DOA/beam result for display and host readout.

Parameters:
- TIMEOUT_CYC, 2000000, max cycles any stage may take before error (one count per clk).
- HOLDOFF_CYC, 50000, idle cycles inserted after each result before the next frame in continuous mode.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset (0 = reset)
- run  input  1  level; 1 = continuous frames
- single  input  1  pulse; run one frame when idle
- clr_err  input  1  pulse; leave ERROR state
- frame_ready  input  1  level; capture buffer holds a full frame
- frame_ack  output  1  1-cycle pulse; frame consumed
- fft_start  output  1  1-cycle pulse to all 4 FFT channels
- fft_done  input  4  per-channel 1-cycle done pulses (any order, any cycles)
- detect_start  output  1  1-cycle pulse to freq detect
- detectdone  input  1  freq detect complete (pulse or level; rising edge used)
- wb_done  input  1  weight block 1-cycle done pulse
- doa_in  input  8  signed DOA from weight block (-90..90)
- bnum_in  input  6  winning beam number (0..36)
- doa_out  output  8  signed latched DOA
- bnum_out  output  6  latched beam
- doa_valid  output  1  1-cycle pulse when doa_out updates
- busy  output  1  1 in any state except IDLE/ERROR
- err  output  1  1 while in ERROR
- err_stage  output  2  stage that timed out: 1 = FFT, 2 = DETECT, 3 = BEAM; 0 = none
- frame_cnt  output  16  completed frames, wraps 0xFFFF -> 0

Behaviour:
- Reset (async, asserted): state = IDLE.
  - All outputs 0: doa_out, bnum_out, frame_cnt, err_stage, all pulses.
  - Internal fft_seen[3:0] = 0; timer = 0.
- States: IDLE, WAITFRM, FFT, DETECT, BEAM, HOLD, ERROR.
- IDLE:
  - run = 1 or single = 1 -> WAITFRM.
  - A single arriving while not in IDLE is ignored (not queued).
- WAITFRM (no timeout):
  - When frame_ready = 1: frame_ack and fft_start pulse in the same cycle; clear fft_seen; -> FFT next cycle.
  - run = 0 while waiting with no single pending -> IDLE.
- FFT:
  - fft_seen |= fft_done each cycle.
  - fft_seen == 4'hF (including bits set this cycle) -> detect_start pulse, -> DETECT.
  - Duplicate done pulses are harmless.
- DETECT:
  - Rising edge of detectdone -> BEAM.
  - detectdone already high on entry does not count; a rising edge is required.
- BEAM:
  - On wb_done: doa_out <= doa_in, bnum_out <= bnum_in.
  - doa_valid pulses the following cycle, coincident with doa_out updated.
  - frame_cnt += 1; -> HOLD.
- HOLD:
  - Counts HOLDOFF_CYC cycles.
  - Then -> WAITFRM if run = 1, else IDLE.
  - single-initiated frames return to IDLE after HOLD.
- Timer:
  - Cleared on entry to FFT, DETECT, BEAM; increments each cycle in those states.
  - Reaching TIMEOUT_CYC-1 without completion -> ERROR; err_stage = current stage code.
  - Completion in the same cycle as expiry wins; no error.
- ERROR:
  - err = 1, busy = 0; doa_out/bnum_out hold their last values.
  - clr_err -> IDLE; err_stage cleared to 0 on exit.
  - Stray done pulses are ignored.
- Output rules: pulses are exactly one cycle. Done inputs seen in IDLE/WAITFRM/HOLD are ignored. fft_seen is not carried across frames.
- Reset mid-frame: immediate return to IDLE; no pulse is generated during or on release of reset.

Optional Feature:
- Macro DOA_AVG_EN.
- Defined:
  - doa_out = signed average of the last 4 accepted doa_in values: 10-bit signed sum, arithmetic shift right by 2, truncation toward -inf.
  - Until 4 results have been accepted since reset, doa_out = raw doa_in.
  - History is cleared by reset only.
  - bnum_out stays raw.
- Undefined: doa_out = raw latched doa_in; no history registers.

Test Plan:
- single pulse with frame_ready = 1, fft_done bits arriving 3, 0, 2, 1 on separate cycles, detectdone rise, wb_done with doa_in = -35, bnum_in = 11 -> exactly one each of frame_ack/fft_start/detect_start; doa_out = -35, bnum_out = 11, doa_valid one cycle, frame_cnt = 1, state returns to IDLE.
- run = 1, 3 frames, HOLDOFF_CYC = 10 -> 3 doa_valid pulses; ≥10 idle cycles between wb_done and the next fft_start; frame_cnt = 3. Drop run during frame 3 -> IDLE after HOLD.
- TIMEOUT_CYC = 100, only fft_done = 4'b0111 given -> err = 1, err_stage = 1 at cycle 100 after entering FFT; late fft_done[3] ignored; clr_err -> IDLE, err_stage = 0.
- wb_done on the exact expiry cycle of BEAM -> result accepted, err stays 0.
- Assert reset during DETECT -> all outputs 0 asynchronously; after release no detect_start/doa_valid until a new run/single.
- DOA_AVG_EN defined, doa_in sequence 10, 20, -30, 40, 50 -> doa_out 10, 20, -30, 10, 20.
